read_port_mc: RTL and testbench
===============================

Name: read_port_mc

Overview:
- Next-generation read port between one requesting module (conv, datasaver, misc) and GRP_NUM image-group arbiters.
- Routes each request to the one-hot selected arbiter.
- Limits in-flight reads with a credit counter so returned data can never overflow the internal buffer.
- Merges returned data from all groups into an internal circular FIFO and presents it through a registered valid/ready output stage.
- Raises sticky error flags on protocol violations.

Parameters:
GRP_NUM, 3, number of image-group arbiters (>=1)
ROW_PARA, 4, bank-enable width
ADDR_WIDTH, 48, request address width
DATA_WIDTH, 256, data word width
FIFO_DEPTH, 32, return-buffer entries; power of 2, >=4; also the maximum outstanding reads
STALL_MARGIN, 5, arb_nostall_o is deasserted when free FIFO entries < STALL_MARGIN
CNT_WIDTH, 6, width of outstanding_o; must hold FIFO_DEPTH

Ports:
clk  in  1  clock
rst_n  in  1  reset
req_valid_i  in  1  request valid
req_group_id_i  in  GRP_NUM  one-hot target group
req_bank_en_i  in  ROW_PARA  bank enables
req_addr_i  in  ADDR_WIDTH  read address
req_ready_o  out  1  request accepted this cycle when high together with req_valid_i
rd_data_valid_o  out  1  output word valid
rd_data_o  out  DATA_WIDTH  output word
rd_data_ready_i  in  1  consumer ready
arb_en_o  out  GRP_NUM  per-group read enable
arb_bank_en_o  out  ROW_PARA  bank enables, broadcast to all groups
arb_addr_o  out  ADDR_WIDTH  address, broadcast to all groups
arb_addr_ready_i  in  GRP_NUM  per-group address ready
arb_data_valid_i  in  GRP_NUM  per-group return valid
arb_data_i  in  GRP_NUM*DATA_WIDTH  return data; group g occupies bits [g*DATA_WIDTH +: DATA_WIDTH]
arb_nostall_o  out  1  arbiters may keep issuing returns
outstanding_o  out  CNT_WIDTH  reads accepted but not yet consumed
err_clr_i  in  1  clears the sticky errors
err_o  out  3  sticky errors: [0] collision, [1] overflow, [2] bad group id

Interface rule (already decided): one clock, clk; reset rst_n is asynchronous and active-low.

Behaviour:
- Reset: all outputs are 0, except arb_nostall_o = 1. FIFO pointers, credit counter and errors are cleared.
- Reset asserted mid-operation discards buffered and in-flight data. Returns arriving while rst_n is low are ignored.
- Definitions:
  - onehot = req_group_id_i has exactly one bit set.
  - credit_ok = outstanding_o < FIFO_DEPTH.
  - go = req_valid_i & onehot & credit_ok.
- arb_en_o = req_group_id_i when go, else 0. This is combinational.
- arb_addr_o = req_addr_i and arb_bank_en_o = req_bank_en_i at all times.
- req_ready_o = go & |(req_group_id_i & arb_addr_ready_i). This is combinational.
- A request is accepted on a cycle where req_valid_i & req_ready_o.
- Credit counter, updated every clock edge:
  - +1 on accept.
  - -1 on output handshake (rd_data_valid_o & rd_data_ready_i).
  - Both in the same cycle: no change.
  - Never wraps; outstanding_o is capped at FIFO_DEPTH by credit_ok.
- FIFO write:
  - Written when |arb_data_valid_i.
  - Data is the lowest-index valid group's slice.
  - Write and read in the same cycle are allowed, including when the FIFO is full, provided a read occurs that cycle.
- Collision: more than one arb_data_valid_i bit set sets err_o[0]. Only one word is written.
- Overflow: a write while full with no simultaneous read sets err_o[1] and drops the word; pointers are unchanged. This is unreachable if arbiters honour the credit limit.
- Bad group id: req_valid_i with non-one-hot req_group_id_i sets err_o[2]. No request is issued and req_ready_o = 0.
- Error flags are sticky. They clear on err_clr_i (synchronous) or reset. If a set and err_clr_i occur in the same cycle, set wins.
- Output stage:
  - One holding register; FIFO pops into it when the register is empty or being consumed this cycle.
  - rd_data_o and rd_data_valid_o are registered and hold steady while rd_data_valid_o & ~rd_data_ready_i.
  - Latency: a return sampled at edge k with FIFO and register empty gives rd_data_valid_o high after edge k+1.
  - Full throughput is one word per cycle while rd_data_ready_i stays high.
- arb_nostall_o = (FIFO_DEPTH - fifo_count) >= STALL_MARGIN, registered.
- Return order equals arrival order. Cross-group ordering is the arbiters' responsibility.

Test Plan:
- Reset: drive rst_n low mid-stream with 3 words buffered -> immediately rd_data_valid_o = 0, outstanding_o = 0, err_o = 0, arb_nostall_o = 1; no stale data appears after release.
- Routing: req_group_id_i = 3'b010, arb_addr_ready_i = 3'b010, addr 0x1234 -> arb_en_o = 3'b010, req_ready_o = 1, outstanding_o = 1. Repeat with arb_addr_ready_i = 3'b001 -> req_ready_o = 0 and the request is held.
- Credit limit: issue 32 requests with no returns -> req_ready_o drops on the 33rd and outstanding_o = 32. One return plus one consumed word -> outstanding_o = 31 and req_ready_o reasserts.
- Latency and backpressure: return D0 at edge 10 -> rd_data_valid_o high after edge 11. Hold rd_data_ready_i = 0 and return D1..D28 -> arb_nostall_o drops when free entries < 5; D0 stays stable. Release -> words come out one per cycle in order D0..D28.
- Errors: arb_data_valid_i = 3'b101 -> err_o[0] = 1 and group 0 data is stored. Request with group id 3'b011 -> err_o[2] = 1 and arb_en_o = 0. Pulse err_clr_i -> err_o = 0.
- Simultaneous: accept and consume in the same cycle -> outstanding_o is unchanged. FIFO write and read in the same cycle while full -> no overflow and err_o[1] stays 0.

Source files
------------

// File: rtl/read_port_mc_if.sv
// Request, read-data and arbiter-side signals of read_port_mc.
// The slave modport is the port's own view; the master modport is the surrounding system's view.
interface read_port_mc_if #(
  parameter int GRP_NUM    = 3,
  parameter int ROW_PARA   = 4,
  parameter int ADDR_WIDTH = 48,
  parameter int DATA_WIDTH = 256
);
  logic                          req_valid_i;
  logic [GRP_NUM-1:0]            req_group_id_i;
  logic [ROW_PARA-1:0]           req_bank_en_i;
  logic [ADDR_WIDTH-1:0]         req_addr_i;
  logic                          req_ready_o;
  logic                          rd_data_valid_o;
  logic [DATA_WIDTH-1:0]         rd_data_o;
  logic                          rd_data_ready_i;
  logic [GRP_NUM-1:0]            arb_en_o;
  logic [ROW_PARA-1:0]           arb_bank_en_o;
  logic [ADDR_WIDTH-1:0]         arb_addr_o;
  logic [GRP_NUM-1:0]            arb_addr_ready_i;
  logic [GRP_NUM-1:0]            arb_data_valid_i;
  logic [GRP_NUM*DATA_WIDTH-1:0] arb_data_i;
  logic                          arb_nostall_o;

  modport slave (
    input  req_valid_i, req_group_id_i, req_bank_en_i, req_addr_i, rd_data_ready_i,
           arb_addr_ready_i, arb_data_valid_i, arb_data_i,
    output req_ready_o, rd_data_valid_o, rd_data_o, arb_en_o, arb_bank_en_o, arb_addr_o,
           arb_nostall_o
  );

  modport master (
    output req_valid_i, req_group_id_i, req_bank_en_i, req_addr_i, rd_data_ready_i,
           arb_addr_ready_i, arb_data_valid_i, arb_data_i,
    input  req_ready_o, rd_data_valid_o, rd_data_o, arb_en_o, arb_bank_en_o, arb_addr_o,
           arb_nostall_o
  );
endinterface

// File: rtl/read_port_mc.sv
// Read port: routes one-hot requests to group arbiters under a credit limit and merges the
// returned words through a circular FIFO into a registered valid/ready output stage.
module read_port_mc #(
  parameter int GRP_NUM      = 3,
  parameter int ROW_PARA     = 4,
  parameter int ADDR_WIDTH   = 48,
  parameter int DATA_WIDTH   = 256,
  parameter int FIFO_DEPTH   = 32,
  parameter int STALL_MARGIN = 5,
  parameter int CNT_WIDTH    = 6
) (
  input  logic                 clk,
  input  logic                 rst_n,
  read_port_mc_if.slave        bus,
  output logic [CNT_WIDTH-1:0] outstanding_o,
  input  logic                 err_clr_i,
  output logic [2:0]           err_o
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CW    = PTR_W + 1;
  localparam logic [CNT_WIDTH-1:0] CREDIT_MAX = CNT_WIDTH'(FIFO_DEPTH);
  localparam logic [CW-1:0]        DEPTH_CNT  = CW'(FIFO_DEPTH);
  localparam logic [CW-1:0]        MARGIN_CNT = CW'(STALL_MARGIN);

  logic [GRP_NUM-1:0]    gid, dv, grp_ready;
  logic                  onehot, credit_ok, go, accept, out_hs;
  logic                  wr_req, wr_en, pop, full, empty, collision, overflow, bad_gid;
  logic [DATA_WIDTH-1:0] sel_data;
  logic [CW-1:0]         count, count_next;

  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [CW-1:0]         wr_ptr_reg, rd_ptr_reg;
  logic [DATA_WIDTH-1:0] rd_data_reg;
  logic                  rd_valid_reg, nostall_reg;
  logic [CNT_WIDTH-1:0]  outstanding_reg, outstanding_next;
  logic [2:0]            err_reg, err_next;

  assign gid       = bus.req_group_id_i;
  assign dv        = bus.arb_data_valid_i;
  assign onehot    = (gid != '0) && ((gid & (gid - GRP_NUM'(1))) == '0);
  assign credit_ok = outstanding_reg < CREDIT_MAX;
  assign go        = bus.req_valid_i & onehot & credit_ok;

  for (genvar gi = 0; gi < GRP_NUM; gi++) begin : g_route
    assign bus.arb_en_o[gi] = go & gid[gi];
    assign grp_ready[gi]    = gid[gi] & bus.arb_addr_ready_i[gi];
  end

  assign bus.req_ready_o   = go & (|grp_ready);
  assign bus.arb_addr_o    = bus.req_addr_i;
  assign bus.arb_bank_en_o = bus.req_bank_en_i;
  assign accept            = bus.req_valid_i & bus.req_ready_o;
  assign out_hs            = rd_valid_reg & bus.rd_data_ready_i;

  // Lowest-index valid group wins when several return in the same cycle.
  always_comb begin
    sel_data = '0;
    for (int g = GRP_NUM - 1; g >= 0; g--) begin
      if (dv[g]) sel_data = bus.arb_data_i[g*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  assign count      = wr_ptr_reg - rd_ptr_reg;
  assign empty      = (count == '0);
  assign full       = (count == DEPTH_CNT);
  assign pop        = ~empty & (~rd_valid_reg | bus.rd_data_ready_i);
  assign wr_req     = |dv;
  assign wr_en      = wr_req & (~full | pop);
  assign count_next = count + CW'(wr_en) - CW'(pop);

  assign collision = (dv & (dv - GRP_NUM'(1))) != '0;
  assign overflow  = wr_req & full & ~pop;
  assign bad_gid   = bus.req_valid_i & ~onehot;
  // A new error in the same cycle as a clear still latches.
  assign err_next  = (err_reg & ~{3{err_clr_i}}) | {bad_gid, overflow, collision};

  always_comb begin
    outstanding_next = outstanding_reg;
    if (accept && !out_hs)
      outstanding_next = outstanding_reg + CNT_WIDTH'(1);
    else if (out_hs && !accept && outstanding_reg != '0)
      outstanding_next = outstanding_reg - CNT_WIDTH'(1);
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr_reg[PTR_W-1:0]] <= sel_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg      <= '0;
      rd_ptr_reg      <= '0;
      rd_data_reg     <= '0;
      rd_valid_reg    <= 1'b0;
      nostall_reg     <= 1'b1;
      outstanding_reg <= '0;
      err_reg         <= '0;
    end else begin
      if (wr_en) wr_ptr_reg <= wr_ptr_reg + CW'(1);
      if (pop) begin
        rd_ptr_reg   <= rd_ptr_reg + CW'(1);
        rd_data_reg  <= mem[rd_ptr_reg[PTR_W-1:0]];
        rd_valid_reg <= 1'b1;
      end else if (out_hs) begin
        rd_valid_reg <= 1'b0;
      end
      nostall_reg     <= (DEPTH_CNT - count_next) >= MARGIN_CNT;
      outstanding_reg <= outstanding_next;
      err_reg         <= err_next;
    end
  end

  assign bus.rd_data_o       = rd_data_reg;
  assign bus.rd_data_valid_o = rd_valid_reg;
  assign bus.arb_nostall_o   = nostall_reg;
  assign outstanding_o       = outstanding_reg;
  assign err_o               = err_reg;
endmodule

// File: tb/tb_read_port_mc.sv
// Bench for read_port_mc: directed scenarios plus random traffic against a queue-based model.
module tb_read_port_mc;
  localparam int GN = 3, RP = 4, AW = 48, DW = 256, DEPTH = 32, MARGIN = 5, CNTW = 6;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            err_clr_i = 1'b0;
  logic [CNTW-1:0] outstanding_o;
  logic [2:0]      err_o;

  read_port_mc_if #(.GRP_NUM(GN), .ROW_PARA(RP), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  read_port_mc #(
    .GRP_NUM(GN), .ROW_PARA(RP), .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
    .FIFO_DEPTH(DEPTH), .STALL_MARGIN(MARGIN), .CNT_WIDTH(CNTW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus.slave),
    .outstanding_o(outstanding_o), .err_clr_i(err_clr_i), .err_o(err_o)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  // Model: every buffered word in arrival order, tagged with the edge that stored it.
  typedef struct { logic [DW-1:0] data; int wr; } entry_t;
  entry_t     mq[$];
  int         cyc = 0;
  int         m_out = 0;
  logic [2:0] m_err = '0;
  bit         m_nostall = 1'b1;

  function automatic bit m_onehot(logic [GN-1:0] g);
    return $countones(g) == 1;
  endfunction

  // A word is presented once it has sat in the port for at least one edge.
  function automatic bit m_valid();
    return mq.size() > 0 && mq[0].wr < cyc;
  endfunction

  function automatic int m_fifo_count();
    return mq.size() - (m_valid() ? 1 : 0);
  endfunction

  function automatic bit m_go();
    return bus.req_valid_i && m_onehot(bus.req_group_id_i) && m_out < DEPTH;
  endfunction

  function automatic bit m_req_ready();
    return m_go() && ((bus.req_group_id_i & bus.arb_addr_ready_i) != '0);
  endfunction

  function automatic logic [GN-1:0] m_arb_en();
    return m_go() ? bus.req_group_id_i : '0;
  endfunction

  function automatic logic [DW-1:0] rnd_word();
    logic [DW-1:0] w;
    for (int i = 0; i < DW / 32; i++) w[i*32 +: 32] = $urandom;
    return w;
  endfunction

  task automatic m_reset();
    mq.delete();
    m_out = 0;
    m_err = '0;
    m_nostall = 1'b1;
  endtask

  task automatic idle();
    bus.req_valid_i      = 1'b0;
    bus.req_group_id_i   = '0;
    bus.req_bank_en_i    = '0;
    bus.req_addr_i       = '0;
    bus.rd_data_ready_i  = 1'b0;
    bus.arb_addr_ready_i = '0;
    bus.arb_data_valid_i = '0;
    bus.arb_data_i       = '0;
    err_clr_i            = 1'b0;
  endtask

  task automatic put_ret(int g, logic [DW-1:0] w);
    bus.arb_data_valid_i       = '0;
    bus.arb_data_valid_i[g]    = 1'b1;
    bus.arb_data_i             = '0;
    bus.arb_data_i[g*DW +: DW] = w;
  endtask

  // Advance one clock edge, updating the model from the inputs present before the edge.
  task automatic tick();
    bit acc, hs, wr, pop, clr;
    int fc;
    logic [2:0] set;
    entry_t e;
    acc = m_req_ready();
    hs  = m_valid() && bus.rd_data_ready_i;
    fc  = m_fifo_count();
    pop = fc > 0 && (!m_valid() || bus.rd_data_ready_i);
    wr  = bus.arb_data_valid_i != '0;
    clr = err_clr_i;
    e.data = '0;
    e.wr = 0;
    for (int g = 0; g < GN; g++) begin
      if (bus.arb_data_valid_i[g]) begin
        e.data = bus.arb_data_i[g*DW +: DW];
        break;
      end
    end
    set = '0;
    set[0] = $countones(bus.arb_data_valid_i) > 1;
    set[1] = wr && fc == DEPTH && !pop;
    set[2] = bus.req_valid_i && !m_onehot(bus.req_group_id_i);
    @(posedge clk);
    if (rst_n) begin
      cyc++;
      if (hs) void'(mq.pop_front());
      if (wr && !set[1]) begin
        e.wr = cyc;
        mq.push_back(e);
      end
      if (acc && !hs) m_out++;
      else if (hs && !acc && m_out > 0) m_out--;
      m_err = (clr ? 3'b000 : m_err) | set;
      m_nostall = (DEPTH - m_fifo_count()) >= MARGIN;
    end
    #1;
  endtask

  task automatic test_reset();
    idle();
    rst_n = 1'b0;
    m_reset();
    tick();
    tick();
    total++; if (bus.rd_data_valid_o !== 1'b0) begin bad++; $display("FAIL reset_valid: got %0b want 0", bus.rd_data_valid_o); end
    total++; if (outstanding_o !== '0) begin bad++; $display("FAIL reset_outstanding: got %0d want 0", outstanding_o); end
    total++; if (err_o !== 3'b000) begin bad++; $display("FAIL reset_err: got %b want 000", err_o); end
    total++; if (bus.arb_nostall_o !== 1'b1) begin bad++; $display("FAIL reset_nostall: got %0b want 1", bus.arb_nostall_o); end
    total++; if (bus.req_ready_o !== 1'b0) begin bad++; $display("FAIL reset_req_ready: got %0b want 0", bus.req_ready_o); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_routing();
    idle();
    bus.req_valid_i      = 1'b1;
    bus.req_group_id_i   = 3'b010;
    bus.arb_addr_ready_i = 3'b010;
    bus.req_addr_i       = 48'h1234;
    bus.req_bank_en_i    = 4'b1010;
    #1;
    total++; if (bus.arb_en_o !== m_arb_en()) begin bad++; $display("FAIL route_arb_en: got %b want %b", bus.arb_en_o, m_arb_en()); end
    total++; if (bus.req_ready_o !== m_req_ready()) begin bad++; $display("FAIL route_ready: got %0b want %0b", bus.req_ready_o, m_req_ready()); end
    total++; if (bus.arb_addr_o !== 48'h1234 || bus.arb_bank_en_o !== 4'b1010) begin bad++; $display("FAIL route_addr: got %h/%b want 1234/1010", bus.arb_addr_o, bus.arb_bank_en_o); end
    tick();
    total++; if (outstanding_o !== CNTW'(m_out)) begin bad++; $display("FAIL route_outstanding: got %0d want %0d", outstanding_o, m_out); end
    bus.arb_addr_ready_i = 3'b001;
    #1;
    total++; if (bus.req_ready_o !== m_req_ready()) begin bad++; $display("FAIL route_held_ready: got %0b want %0b", bus.req_ready_o, m_req_ready()); end
    total++; if (bus.arb_en_o !== m_arb_en()) begin bad++; $display("FAIL route_held_en: got %b want %b", bus.arb_en_o, m_arb_en()); end
    tick();
    total++; if (outstanding_o !== CNTW'(m_out)) begin bad++; $display("FAIL route_held_out: got %0d want %0d", outstanding_o, m_out); end
    idle();
  endtask

  task automatic test_credit();
    idle();
    bus.arb_addr_ready_i = '1;
    for (int n = 0; n < 40 && m_out < DEPTH; n++) begin
      bus.req_valid_i    = 1'b1;
      bus.req_group_id_i = 3'b001 << $urandom_range(0, 2);
      bus.req_addr_i     = {$urandom, 16'h0};
      tick();
    end
    bus.req_valid_i = 1'b1;
    #1;
    total++; if (bus.req_ready_o !== m_req_ready()) begin bad++; $display("FAIL credit_block: got %0b want %0b", bus.req_ready_o, m_req_ready()); end
    total++; if (outstanding_o !== CNTW'(m_out)) begin bad++; $display("FAIL credit_full: got %0d want %0d", outstanding_o, m_out); end
    bus.req_valid_i = 1'b0;
    put_ret(0, rnd_word());
    tick();
    bus.arb_data_valid_i = '0;
    tick();
    bus.rd_data_ready_i = 1'b1;
    tick();
    bus.rd_data_ready_i = 1'b0;
    bus.req_valid_i = 1'b1;
    #1;
    total++; if (outstanding_o !== CNTW'(m_out)) begin bad++; $display("FAIL credit_return: got %0d want %0d", outstanding_o, m_out); end
    total++; if (bus.req_ready_o !== m_req_ready()) begin bad++; $display("FAIL credit_reopen: got %0b want %0b", bus.req_ready_o, m_req_ready()); end
    tick();
    bus.req_valid_i = 1'b0;
    bus.rd_data_ready_i = 1'b1;
    for (int n = 0; n < DEPTH; n++) begin
      put_ret(n % GN, rnd_word());
      tick();
    end
    bus.arb_data_valid_i = '0;
    for (int n = 0; n < 10 && mq.size() > 0; n++) tick();
    total++; if (outstanding_o !== CNTW'(m_out)) begin bad++; $display("FAIL credit_drain: got %0d want %0d", outstanding_o, m_out); end
    idle();
  endtask

  task automatic test_latency_backpressure();
    logic [DW-1:0] words [29];
    int got;
    idle();
    for (int i = 0; i < 29; i++) words[i] = rnd_word();
    put_ret(0, words[0]);
    tick();
    idle();
    #1;
    total++; if (bus.rd_data_valid_o !== 1'b0) begin bad++; $display("FAIL lat_early: got %0b want 0", bus.rd_data_valid_o); end
    tick();
    total++; if (bus.rd_data_valid_o !== 1'b1 || bus.rd_data_o !== words[0]) begin bad++; $display("FAIL lat_d0: got %0b/%h want 1/%h", bus.rd_data_valid_o, bus.rd_data_o, words[0]); end
    for (int i = 1; i < 29; i++) begin
      put_ret(i % GN, words[i]);
      tick();
      total++; if (bus.rd_data_o !== words[0] || bus.rd_data_valid_o !== 1'b1) begin bad++; $display("FAIL bp_hold%0d: got %h want %h", i, bus.rd_data_o, words[0]); end
      total++; if (bus.arb_nostall_o !== m_nostall) begin bad++; $display("FAIL bp_nostall%0d: got %0b want %0b", i, bus.arb_nostall_o, m_nostall); end
    end
    idle();
    tick();
    total++; if (bus.arb_nostall_o !== m_nostall) begin bad++; $display("FAIL bp_stall: got %0b want %0b", bus.arb_nostall_o, m_nostall); end
    bus.rd_data_ready_i = 1'b1;
    got = 0;
    for (int n = 0; n < 60 && got < 29; n++) begin
      total++; if (bus.rd_data_valid_o !== 1'b1 || bus.rd_data_o !== words[got]) begin bad++; $display("FAIL drain_d%0d: got %0b/%h want 1/%h", got, bus.rd_data_valid_o, bus.rd_data_o, words[got]); end
      got++;
      tick();
    end
    total++; if (bus.rd_data_valid_o !== 1'b0) begin bad++; $display("FAIL drain_end: got %0b want 0", bus.rd_data_valid_o); end
    idle();
  endtask

  task automatic test_errors();
    logic [DW-1:0] a, b;
    idle();
    a = rnd_word();
    b = rnd_word();
    bus.arb_data_valid_i     = 3'b101;
    bus.arb_data_i[0 +: DW]  = a;
    bus.arb_data_i[2*DW +: DW] = b;
    tick();
    idle();
    total++; if (err_o !== m_err) begin bad++; $display("FAIL err_collision: got %b want %b", err_o, m_err); end
    tick();
    total++; if (bus.rd_data_o !== a) begin bad++; $display("FAIL err_coll_data: got %h want %h", bus.rd_data_o, a); end
    bus.rd_data_ready_i = 1'b1;
    tick();
    idle();
    bus.req_valid_i      = 1'b1;
    bus.req_group_id_i   = 3'b011;
    bus.arb_addr_ready_i = '1;
    #1;
    total++; if (bus.arb_en_o !== 3'b000 || bus.req_ready_o !== 1'b0) begin bad++; $display("FAIL err_badgid_issue: got %b/%0b want 000/0", bus.arb_en_o, bus.req_ready_o); end
    tick();
    idle();
    total++; if (err_o !== m_err) begin bad++; $display("FAIL err_badgid: got %b want %b", err_o, m_err); end
    err_clr_i = 1'b1;
    tick();
    idle();
    total++; if (err_o !== 3'b000) begin bad++; $display("FAIL err_clear: got %b want 000", err_o); end
    bus.arb_data_valid_i = 3'b110;
    err_clr_i = 1'b1;
    tick();
    idle();
    total++; if (err_o !== m_err) begin bad++; $display("FAIL err_set_wins: got %b want %b", err_o, m_err); end
    err_clr_i = 1'b1;
    bus.rd_data_ready_i = 1'b1;
    for (int n = 0; n < 3; n++) tick();
    idle();
  endtask

  task automatic test_simultaneous();
    int exp_out;
    idle();
    bus.arb_addr_ready_i = '1;
    bus.req_valid_i      = 1'b1;
    bus.req_group_id_i   = 3'b001;
    tick();
    idle();
    put_ret(1, rnd_word());
    tick();
    idle();
    tick();
    exp_out = m_out;
    bus.req_valid_i      = 1'b1;
    bus.req_group_id_i   = 3'b100;
    bus.arb_addr_ready_i = '1;
    bus.rd_data_ready_i  = 1'b1;
    tick();
    idle();
    total++; if (outstanding_o !== CNTW'(exp_out)) begin bad++; $display("FAIL sim_credit: got %0d want %0d", outstanding_o, exp_out); end
    for (int n = 0; n < DEPTH + 1; n++) begin
      put_ret(n % GN, rnd_word());
      tick();
    end
    idle();
    total++; if (bus.arb_nostall_o !== m_nostall) begin bad++; $display("FAIL sim_full_nostall: got %0b want %0b", bus.arb_nostall_o, m_nostall); end
    put_ret(0, rnd_word());
    bus.rd_data_ready_i = 1'b1;
    tick();
    idle();
    total++; if (err_o[1] !== 1'b0) begin bad++; $display("FAIL sim_full_rw: got %0b want 0", err_o[1]); end
    put_ret(2, rnd_word());
    tick();
    idle();
    total++; if (err_o !== m_err) begin bad++; $display("FAIL sim_overflow: got %b want %b", err_o, m_err); end
    err_clr_i = 1'b1;
    tick();
    idle();
    bus.rd_data_ready_i = 1'b1;
    for (int n = 0; n < 80 && mq.size() > 0; n++) begin
      total++; if (bus.rd_data_valid_o !== m_valid() || (m_valid() && bus.rd_data_o !== mq[0].data)) begin bad++; $display("FAIL sim_drain: got %0b/%h want %0b", bus.rd_data_valid_o, bus.rd_data_o, m_valid()); end
      tick();
    end
    total++; if (bus.rd_data_valid_o !== 1'b0) begin bad++; $display("FAIL sim_drain_end: got %0b want 0", bus.rd_data_valid_o); end
    idle();
  endtask

  task automatic test_random();
    int r;
    for (int n = 0; n < 400; n++) begin
      bus.req_valid_i = 1'($urandom_range(0, 1));
      r = $urandom_range(0, 9);
      bus.req_group_id_i   = (r < 8) ? (3'b001 << (r % 3)) : 3'($urandom);
      bus.req_addr_i       = {$urandom, 16'($urandom)};
      bus.req_bank_en_i    = 4'($urandom);
      bus.arb_addr_ready_i = 3'($urandom);
      r = $urandom_range(0, 9);
      bus.arb_data_valid_i = (r < 5) ? 3'b000 : (r < 9) ? (3'b001 << (r % 3)) : 3'($urandom);
      for (int g = 0; g < GN; g++) bus.arb_data_i[g*DW +: DW] = rnd_word();
      bus.rd_data_ready_i = $urandom_range(0, 3) != 0;
      err_clr_i = $urandom_range(0, 15) == 0;
      #1;
      total++; if (bus.req_ready_o !== m_req_ready()) begin bad++; $display("FAIL rnd_ready c%0d: got %0b want %0b", n, bus.req_ready_o, m_req_ready()); end
      total++; if (bus.arb_en_o !== m_arb_en()) begin bad++; $display("FAIL rnd_arb_en c%0d: got %b want %b", n, bus.arb_en_o, m_arb_en()); end
      total++; if (bus.rd_data_valid_o !== m_valid()) begin bad++; $display("FAIL rnd_valid c%0d: got %0b want %0b", n, bus.rd_data_valid_o, m_valid()); end
      if (m_valid()) begin
        total++; if (bus.rd_data_o !== mq[0].data) begin bad++; $display("FAIL rnd_data c%0d: got %h want %h", n, bus.rd_data_o, mq[0].data); end
      end
      total++; if (outstanding_o !== CNTW'(m_out)) begin bad++; $display("FAIL rnd_out c%0d: got %0d want %0d", n, outstanding_o, m_out); end
      total++; if (err_o !== m_err) begin bad++; $display("FAIL rnd_err c%0d: got %b want %b", n, err_o, m_err); end
      total++; if (bus.arb_nostall_o !== m_nostall) begin bad++; $display("FAIL rnd_nostall c%0d: got %0b want %0b", n, bus.arb_nostall_o, m_nostall); end
      tick();
    end
    idle();
  endtask

  task automatic test_reset_midstream();
    idle();
    bus.arb_addr_ready_i = '1;
    bus.req_valid_i      = 1'b1;
    bus.req_group_id_i   = 3'b001;
    tick();
    tick();
    idle();
    for (int i = 0; i < 3; i++) begin
      put_ret(i % GN, rnd_word());
      tick();
    end
    idle();
    tick();
    #2;
    rst_n = 1'b0;
    m_reset();
    #1;
    total++; if (bus.rd_data_valid_o !== 1'b0) begin bad++; $display("FAIL mid_reset_valid: got %0b want 0", bus.rd_data_valid_o); end
    total++; if (outstanding_o !== '0) begin bad++; $display("FAIL mid_reset_out: got %0d want 0", outstanding_o); end
    total++; if (err_o !== 3'b000) begin bad++; $display("FAIL mid_reset_err: got %b want 000", err_o); end
    total++; if (bus.arb_nostall_o !== 1'b1) begin bad++; $display("FAIL mid_reset_nostall: got %0b want 1", bus.arb_nostall_o); end
    put_ret(0, rnd_word());
    tick();
    tick();
    idle();
    rst_n = 1'b1;
    bus.rd_data_ready_i = 1'b1;
    for (int n = 0; n < 5; n++) begin
      tick();
      total++; if (bus.rd_data_valid_o !== 1'b0) begin bad++; $display("FAIL mid_reset_stale%0d: got %0b want 0", n, bus.rd_data_valid_o); end
    end
    idle();
  endtask

  initial begin
    test_reset();
    test_routing();
    test_credit();
    test_latency_backpressure();
    test_errors();
    test_simultaneous();
    test_random();
    test_reset_midstream();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
